// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one unsigned compare/max datapath between two requesters.
// Each granted operation takes IDLE -> EXEC -> DONE and returns a registered result with a done pulse.
module compare_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [1:0]       sel0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [1:0]       sel1,
    output logic             grant0,
    output logic             grant1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             win1;
    logic [WIDTH-1:0] cmp_val;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign win1 = req1 && (!req0 || !last_grant_q);

    always_comb begin
        cmp_val = '0;
        case (sel_q)
            2'd0:    cmp_val[0] = (x_q == y_q);
            2'd1:    cmp_val[0] = (x_q > y_q);
            2'd2:    cmp_val[0] = (x_q < y_q);
            default: cmp_val    = (x_q < y_q) ? y_q : x_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        x_d          = x_q;
        y_d          = y_q;
        sel_d        = sel_q;
        result_d     = result_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = win1;
                    x_d     = win1 ? x1 : x0;
                    y_d     = win1 ? y1 : y0;
                    sel_d   = win1 ? sel1 : sel0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = cmp_val;
                state_d  = DONE;
            end
            DONE: begin
                op_count_d   = op_count_q + CNT_W'(1);
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            sel_q        <= '0;
            result_q     <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sel_q        <= sel_d;
            result_q     <= result_d;
            op_count_q   <= op_count_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign grant0   = busy && !owner_q;
    assign grant1   = busy && owner_q;
    assign done0    = (state_q == DONE) && !owner_q;
    assign done1    = (state_q == DONE) && owner_q;
    assign result   = result_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Scoreboard bench for compare_arbiter: driver pushes predicted (requester, result) pairs,
// a negedge monitor pops them whenever a done pulse appears.
module tb_compare_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [1:0] sel0 = '0, sel1 = '0;
    logic       grant0, grant1, done0, done1, busy;
    logic [3:0] result;
    logic [7:0] op_count;

    compare_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .x0(x0), .y0(y0), .sel0(sel0),
        .req1(req1), .x1(x1), .y1(y1), .sel1(sel1),
        .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
        .result(result), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       who;
        logic [3:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   last_gnt = 1'b1;
    logic [7:0] exp_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return {3'b000, a == b};
            2'd1:    return {3'b000, a > b};
            2'd2:    return {3'b000, a < b};
            default: return (a >= b) ? a : b;
        endcase
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_count = '0;
            end else begin
                check("busy_grant", {30'd0, busy, grant0 ^ grant1}, {30'd0, grant0 | grant1, busy});
                if (done0 || done1) begin
                    check("done_onehot", {31'd0, done0 & done1}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_owner", {31'd0, done1}, {31'd0, e.who});
                        check("done_grant", {30'd0, grant1, grant0}, {30'd0, e.who, ~e.who});
                        check("result", {28'd0, result}, {28'd0, e.res});
                        check("op_count", {24'd0, op_count}, {24'd0, exp_count});
                        exp_count = exp_count + 8'd1;
                    end
                end
            end
        end
    end

    // One request round: r0/r1 select which requesters raise req at the same time.
    task automatic do_round(input bit r0, input bit r1,
                            input logic [3:0] ax, input logic [3:0] ay, input logic [1:0] as_,
                            input logic [3:0] bx, input logic [3:0] by, input logic [1:0] bs);
        exp_t e;
        bit   first;
        bit   p0, p1;
        int   cyc;
        int   lat0, lat1;
        @(negedge clk);
        x0 = ax; y0 = ay; sel0 = as_;
        x1 = bx; y1 = by; sel1 = bs;
        req0 = r0; req1 = r1;
        first = (r0 && r1) ? ~last_gnt : r1;
        lat0 = (r0 && r1 && first) ? 5 : 2;
        lat1 = (r0 && r1 && !first) ? 5 : 2;
        if (r0 && r1) begin
            e.who = first;
            e.res = first ? ref_op(bx, by, bs) : ref_op(ax, ay, as_);
            exp_q.push_back(e);
            e.who = ~first;
            e.res = first ? ref_op(ax, ay, as_) : ref_op(bx, by, bs);
            exp_q.push_back(e);
            last_gnt = ~first;
        end else begin
            e.who = first;
            e.res = first ? ref_op(bx, by, bs) : ref_op(ax, ay, as_);
            exp_q.push_back(e);
            last_gnt = first;
        end
        p0 = r0; p1 = r1; cyc = 0;
        while ((p0 || p1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            // Scramble the owner's operands mid-flight; latched values must be used.
            if (grant0 && !done0) begin x0 = 4'hF; y0 = 4'($urandom); sel0 = 2'($urandom); end
            if (grant1 && !done1) begin x1 = 4'hF; y1 = 4'($urandom); sel1 = 2'($urandom); end
            if (done0 && p0) begin
                check("latency0", cyc, lat0);
                req0 = 1'b0; p0 = 1'b0;
            end
            if (done1 && p1) begin
                check("latency1", cyc, lat1);
                req1 = 1'b0; p1 = 1'b0;
            end
        end
        if (p0 || p1) begin
            check("round_timeout", 32'd1, 32'd0);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    initial begin
        int mode;
        repeat (2) @(negedge clk);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_grants",   {30'd0, grant1, grant0}, 32'd0);
        check("rst_dones",    {30'd0, done1, done0}, 32'd0);
        check("rst_result",   {28'd0, result}, 32'd0);
        check("rst_op_count", {24'd0, op_count}, 32'd0);
        rst = 1'b0;

        do_round(1, 0, 4'd5, 4'd5, 2'd0, 4'd0, 4'd0, 2'd0);
        do_round(0, 1, 4'd0, 4'd0, 2'd0, 4'd3, 4'd9, 2'd3);
        do_round(0, 1, 4'd0, 4'd0, 2'd0, 4'd9, 4'd9, 2'd1);
        do_round(1, 1, 4'd7, 4'd2, 2'd1, 4'd2, 4'd7, 2'd2);
        do_round(1, 1, 4'd7, 4'd2, 2'd1, 4'd2, 4'd7, 2'd2);
        do_round(1, 0, 4'd4, 4'd6, 2'd3, 4'd0, 4'd0, 2'd0);
        check("op_count_after_directed", {24'd0, op_count}, 32'd7);

        // Reset in the EXEC cycle: the operation must vanish without a done pulse.
        @(negedge clk);
        x0 = 4'd1; y0 = 4'd2; sel0 = 2'd2; req0 = 1'b1;
        @(negedge clk);
        check("pre_rst_grant0", {31'd0, grant0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_outputs", {21'd0, busy, grant0, grant1, done0, done1, op_count, result},
              32'd0);
        req0 = 1'b0;
        last_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_rst_result", {28'd0, result}, 32'd0);
        #2 rst = 1'b0;
        do_round(1, 1, 4'd8, 4'd3, 2'd3, 4'd3, 4'd8, 2'd3);

        repeat (300) begin
            mode = $urandom_range(0, 2);
            do_round(mode != 1, mode != 0,
                     4'($urandom), 4'($urandom), 2'($urandom),
                     4'($urandom), 4'($urandom), 2'($urandom));
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("final_op_count", {24'd0, op_count}, {24'd0, exp_count});
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
